// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Multi-cycle multiply/divide sequencer for MULT, MULTU, DIV and DIVU.
// It latches the operands on start and iterates one bit per cycle while it
// holds the pipeline through stallreq. It then presents a single cycle of
// hi_we/lo_we/done along with the HI/LO result data.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : EX holds a mul/div instruction (sampled only in IDLE)
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     : multiplicand / dividend
//   src_b     : multiplier / divisor
//   cancel    : flush of the owning instruction; abort without writing
//   stallreq  : pipeline stall request
//   busy      : state is not IDLE
//   done      : one-cycle result-valid pulse
//   hi_we     : HI write enable (with done)
//   lo_we     : LO write enable (with done)
//   hi_wdata  : product high half or remainder
//   lo_wdata  : product low half or quotient
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;

    // multiply datapath
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg_prod;

    // divide datapath
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;
    logic                 neg_quo;
    logic                 neg_rem;

    // result registers driving hi_wdata/lo_wdata
    logic [WIDTH-1:0]     hi_res;
    logic [WIDTH-1:0]     lo_res;

    // combinational helpers
    logic                 is_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_add;
    logic [2*WIDTH-1:0]   prod_final;
    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     diff;
    logic                 q_bit;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     quo_final;
    logic [WIDTH-1:0]     rem_final;

    // Operand magnitudes and the per-iteration shift-add / restoring-divide step
    always_comb begin
        is_signed  = ~op[0];
        sign_a     = is_signed & src_a[WIDTH-1];
        sign_b     = is_signed & src_b[WIDTH-1];
        // The most negative value negates to itself, and it reads correctly as the unsigned 2^(WIDTH-1)
        abs_a      = sign_a ? (~src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : src_a;
        abs_b      = sign_b ? (~src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : src_b;

        acc_add    = acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
        prod_final = neg_prod ? (~acc_add + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_add;

        // Bring the next dividend bit into the partial remainder, then trial-subtract the divisor
        shifted    = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff       = {1'b0, shifted} - {2'b00, divisor};
        q_bit      = ~diff[WIDTH+1];
        rem_next   = q_bit ? diff[WIDTH:0] : shifted;
        quo_next   = {quo[WIDTH-2:0], q_bit};
        quo_final  = neg_quo ? (~quo_next + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_next;
        rem_final  = neg_rem ? (~rem_next[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                             : rem_next[WIDTH-1:0];
    end

    // Sequencer FSM together with its datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= {CNT_W{1'b0}};
            acc      <= {(2*WIDTH){1'b0}};
            mcand    <= {(2*WIDTH){1'b0}};
            mplier   <= {WIDTH{1'b0}};
            neg_prod <= 1'b0;
            rem      <= {(WIDTH+1){1'b0}};
            quo      <= {WIDTH{1'b0}};
            divisor  <= {WIDTH{1'b0}};
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            hi_res   <= {WIDTH{1'b0}};
            lo_res   <= {WIDTH{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        count <= {CNT_W{1'b0}};
                        if (op[1] && (src_b == {WIDTH{1'b0}})) begin
                            // Divide by zero resolves immediately with fixed results
                            hi_res <= src_a;
                            lo_res <= {WIDTH{1'b1}};
                            state  <= ST_DONE;
                        end else if (op[1]) begin
                            rem     <= {(WIDTH+1){1'b0}};
                            quo     <= abs_a;
                            divisor <= abs_b;
                            neg_quo <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            state   <= ST_DIV;
                        end else begin
                            acc      <= {(2*WIDTH){1'b0}};
                            mcand    <= {{WIDTH{1'b0}}, abs_a};
                            mplier   <= abs_b;
                            neg_prod <= sign_a ^ sign_b;
                            state    <= ST_MUL;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        acc    <= acc_add;
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                        count  <= count + CNT_ONE;
                        if (count == CNT_LAST) begin
                            hi_res <= prod_final[2*WIDTH-1:WIDTH];
                            lo_res <= prod_final[WIDTH-1:0];
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_MUL;
                        end
                    end
                end
                ST_DIV: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + CNT_ONE;
                        if (count == CNT_LAST) begin
                            hi_res <= rem_final;
                            lo_res <= quo_final;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // stallreq rises in the start cycle itself so the instruction cannot leave EX early.
    // A cancel arriving in DONE must still suppress the write, so the enables are gated by cancel.
    assign stallreq = ((state == ST_IDLE) & start & ~cancel) | (state == ST_MUL) | (state == ST_DIV);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE) & ~cancel;
    assign hi_we    = done;
    assign lo_we    = done;
    assign hi_wdata = hi_res;
    assign lo_wdata = lo_res;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl
// Directed testbench for hilo_muldiv_ctrl. The expected HI/LO values, the
// latencies and the stall behaviour are all computed by hand.
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        busy;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int tests_run;
    int tests_failed;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and record the outcome
    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one operation from a negedge, then follow it to DONE and one cycle beyond
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input string tag);
        int  cyc;
        int  stall_bad;
        logic seen;
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        check_eq({tag, "_stall0"}, 64'(stallreq), 64'd1);
        @(negedge clk);
        start = 1'b0;
        // Changing the operands after the start cycle must not affect the result
        src_a = $urandom; src_b = $urandom;
        cyc = 1; seen = 1'b0; stall_bad = 0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!stallreq || !busy || hi_we || lo_we) stall_bad++;
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        if (seen) begin
            check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
            check_eq({tag, "_we"}, {62'd0, hi_we, lo_we}, 64'd3);
            check_eq({tag, "_stall_done"}, 64'(stallreq), 64'd0);
            check_eq({tag, "_hi"}, 64'(hi_wdata), 64'(exp_hi));
            check_eq({tag, "_lo"}, 64'(lo_wdata), 64'(exp_lo));
            // start is ignored in DONE, so the next cycle is IDLE
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
            check_eq({tag, "_hold"}, {hi_wdata, lo_wdata}, {exp_hi, exp_lo});
        end
    endtask

    // Main directed sequence
    initial begin
        int cnt_bad;
        clk = 1'b0; rst = 1'b1; start = 1'b0; op = 2'b00;
        src_a = 32'd0; src_b = 32'd0; cancel = 1'b0;
        tests_run = 0; tests_failed = 0;

        @(negedge clk);
        check_eq("reset_ctrl", {59'd0, stallreq, busy, done, hi_we, lo_we}, 64'd0);
        check_eq("reset_data", {hi_wdata, lo_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 33, "mult_m3x5");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max");
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, "mult_min");
        run_op(2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 33, "mult_7xm6");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7d2");
        run_op(2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, "divu_100d7");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_ovf");
        run_op(2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1,  "divu_by0");
        run_op(2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1,  "div_by0");

        // start together with cancel in IDLE is not accepted
        start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
        #1;
        check_eq("startcancel_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_eq("startcancel_busy", 64'(busy), 64'd0);

        // DIV cancelled in cycle 10: no write, IDLE in cycle 11, then a new op
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt_bad = 0;
        for (int c = 1; c < 10; c++) begin
            if (hi_we || lo_we || done || !busy) cnt_bad++;
            @(negedge clk);
        end
        cancel = 1'b1;
        #1;
        check_eq("cancel_no_we", {61'd0, hi_we, lo_we, done}, 64'd0);
        check_eq("cancel_pre_bad", 64'(cnt_bad), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_idle", {62'd0, busy, hi_we}, 64'd0);
        run_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 33, "after_cancel");

        // Asynchronous reset in cycle 20 of a MULT
        op = 2'b00; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_ctrl", {59'd0, stallreq, busy, done, hi_we, lo_we}, 64'd0);
        check_eq("rst_data", {hi_wdata, lo_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 33, "multu_6x7");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
